exec_seq: RTL
=============

Name: exec_seq

Overview:
Multicycle sequencer that owns the writeback selector's control inputs. It accepts one instruction at a time, classifies its opcode, steps it through EXEC / MEM / WB phases, and drives the selector's opcode and flag inputs from registers that hold steady for the whole instruction. It also issues the data-memory request for load-class opcodes and the register-file write strobe. It sits between the decoder and the ALU/memory/selector datapath.

Parameters:
RA_W, 4, register-file address width
TMO, 255, maximum cycles to wait for mem_ack before error (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
inst_valid  in  1  decoder offers an instruction
inst_ready  out  1  sequencer accepts the instruction this cycle
inst_opc  in  8  opcode (shared instruction macro header encoding)
inst_rd  in  RA_W  destination register
alu_flg  in  2  ALU flags: bit0 = equal/zero, bit1 = less
sel_opc  out  8  opcode to writeback selector (registered)
sel_flg  out  2  flags to writeback selector (registered flag register)
mem_req  out  1  data-memory read request
mem_ack  in  1  memory data valid on the selector d input
rf_we  out  1  register-file write strobe (one cycle)
rf_wa  out  RA_W  register-file write address
busy  out  1  instruction in flight (state != IDLE)
err  out  1  sticky memory-timeout error

Behaviour:
- Reset (async, rst=1): state IDLE; sel_opc=8'h00, sel_flg=2'b00, mem_req=0, rf_we=0, rf_wa=0, err=0, internal timeout counter 0. Reset during any phase aborts the instruction; no rf_we is emitted.
- inst_ready = (state==IDLE) & ~err; combinational. Handshake fires when inst_valid & inst_ready; then inst_opc -> sel_opc and inst_rd -> rf_wa are captured.
- Classes, decided at capture:
  - ALU: opc[7]=1.
  - SET: SETE, SETNE, SETL, SETLE.
  - LOAD: MOVRA4, MOVRA1, MOVRR1.
  - OTHER: everything else.
- States:
  - IDLE -> on handshake: ALU or SET -> EXEC; LOAD -> MEM (mem_req=1 from the next cycle); OTHER -> WB.
  - EXEC (1 cycle): for ALU, sel_flg <= alu_flg at the end of the cycle. SET does not modify sel_flg. Next state is WB.
  - MEM: mem_req held high; the counter increments each cycle.
    - mem_ack=1: mem_req drops the next cycle, go to WB.
    - Counter reaches TMO without ack: mem_req drops, err <= 1, go to IDLE with no write.
    - mem_ack in the same cycle the counter hits TMO: ack wins.
    - Counter clears on entry to MEM.
  - WB (1 cycle): rf_we=1 with rf_wa = captured rd; sel_opc is still stable. Next state is IDLE.
- Latency from handshake to the rf_we cycle:
  - OTHER: 1 cycle.
  - ALU/SET: 2 cycles.
  - LOAD: 2 + N cycles, where N = cycles of mem_req before ack (N >= 0 if ack is already high on the first MEM cycle).
- sel_opc and rf_wa change only on handshake. sel_flg changes only in EXEC for ALU.
- Back-to-back: the next handshake is possible in the cycle after WB (IDLE). Throughput is at most one instruction per 2 cycles.
- err is sticky until reset and blocks new instructions.
- mem_ack outside MEM is ignored.
- inst_valid while busy is ignored (no capture).

Test Plan:
- Reset: assert rst mid-MEM with mem_req=1 -> mem_req, rf_we, busy, err all 0 immediately; sel_opc=00, sel_flg=00.
- ALU op (opc=8'h80, rd=3) with alu_flg=2'b10 during EXEC -> sel_flg=10 from the WB cycle; rf_we=1, rf_wa=3 exactly 2 cycles after handshake.
- SETLE after the above -> sel_flg still 10 during WB, rf_we pulses once; verify the selector outputs 1.
- MOVRA1 with mem_ack after 3 cycles -> mem_req high for exactly 3 cycles, rf_we 1 cycle after ack, sel_opc=MOVRA1 throughout.
- Load with TMO=4 and no ack -> mem_req high 4 cycles, then err=1, no rf_we, inst_ready stays 0 with inst_valid held.
- Back-to-back OTHER opcodes with inst_valid held -> handshakes every 2 cycles; rf_we alternates 1/0; inst_valid while busy is not captured.

Source files
------------

// File: rtl/exec_seq.sv
// Multicycle EXEC/MEM/WB sequencer driving the writeback selector's opcode/flag
// inputs, the data-memory read request and the register-file write strobe.
module exec_seq #(
  parameter int unsigned RA_W = 4,
  parameter int unsigned TMO  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [7:0]      inst_opc,
  input  logic [RA_W-1:0] inst_rd,
  input  logic [1:0]      alu_flg,
  output logic [7:0]      sel_opc,
  output logic [1:0]      sel_flg,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_wa,
  output logic            busy,
  output logic            err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [7:0] OPC_SETE   = 8'h10;
  localparam logic [7:0] OPC_SETNE  = 8'h11;
  localparam logic [7:0] OPC_SETL   = 8'h12;
  localparam logic [7:0] OPC_SETLE  = 8'h13;
  localparam logic [7:0] OPC_MOVRA4 = 8'h20;
  localparam logic [7:0] OPC_MOVRA1 = 8'h21;
  localparam logic [7:0] OPC_MOVRR1 = 8'h22;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e             state_q;
  logic [7:0]         sel_opc_q;
  logic [1:0]         sel_flg_q;
  logic               mem_req_q;
  logic               rf_we_q;
  logic [RA_W-1:0]    rf_wa_q;
  logic               busy_q;
  logic               err_q;
  logic               is_alu_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               fire;
  logic               opc_is_set;
  logic               opc_is_load;

  assign inst_ready  = (state_q == S_IDLE) & ~err_q;
  assign fire        = inst_valid & inst_ready;
  assign cnt_d       = cnt_q + CNT_W'(1);

  // Opcode class decode on the incoming instruction
  assign opc_is_set  = (inst_opc == OPC_SETE) | (inst_opc == OPC_SETNE) |
                       (inst_opc == OPC_SETL) | (inst_opc == OPC_SETLE);
  assign opc_is_load = (inst_opc == OPC_MOVRA4) | (inst_opc == OPC_MOVRA1) |
                       (inst_opc == OPC_MOVRR1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_opc_q <= 8'h00;
      sel_flg_q <= 2'b00;
      mem_req_q <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      is_alu_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fire) begin
            sel_opc_q <= inst_opc;
            rf_wa_q   <= inst_rd;
            is_alu_q  <= inst_opc[7];
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            if (inst_opc[7] | opc_is_set) begin
              state_q <= S_EXEC;
            end else if (opc_is_load) begin
              state_q   <= S_MEM;
              mem_req_q <= 1'b1;
            end else begin
              state_q <= S_WB;
              rf_we_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (is_alu_q) begin
            sel_flg_q <= alu_flg;
          end
          state_q <= S_WB;
          rf_we_q <= 1'b1;
        end
        S_MEM: begin
          cnt_q <= cnt_d;
          // Ack takes priority over a timeout landing in the same cycle
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WB;
            rf_we_q   <= 1'b1;
          end else if (cnt_d == CNT_W'(TMO)) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_WB: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sel_opc = sel_opc_q;
  assign sel_flg = sel_flg_q;
  assign mem_req = mem_req_q;
  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
